io_arbiter: RTL and testbench
=============================

# io_arbiter

Two-port IO bus arbiter and SRAM sequencer. It sits between the CPU's IO port and the board SRAM, with a second requester port for the DMA or debug loader. It grants one requester at a time by round-robin and runs a fixed wait-state SRAM cycle. It also generates byte enables and read extension from the IO mode, and returns data with a one-cycle ready pulse.

## Interface
Parameters:
- SRAM_WAIT, 2: number of cycles WE_n is held low (write) and extra cycles of read settling. Must be ≥1.
- SRAM_AW, 20: SRAM word-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- m0_mode  in  4  CPU request; `IO_NOP` means idle; codes come from defs.v.
- m0_addr  in  32  CPU byte address.
- m0_wdata  in  32  CPU store data.
- m0_rdata  out  32  read result; valid while m0_ready.
- m0_ready  out  1  one-cycle completion pulse.
- m1_mode, m1_addr, m1_wdata, m1_rdata, m1_ready: same as the m0 signals, for the second requester.
- sram_addr  out  SRAM_AW  word address, taken from addr[SRAM_AW+1:2].
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data.
- sram_be_n  out  4  byte enables, active-low.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  strobes, active-low.

## Operation
- Request: a port requests when its mode ≠ `IO_NOP`. Mode, addr and wdata must stay stable until that port's ready pulse.
- Arbitration in IDLE:
  - If only one port requests, it is granted.
  - If both request, the port not granted last time wins.
  - The last-grant register resets to 1, so m0 wins the first tie.
- Address map:
  - SRAM hit when addr[31:22] == 10'h200 (0x80000000–0x803FFFFF).
  - On a miss, no strobes are asserted, rdata = 0, and latency is identical to a hit.
- Modes:
  - LW / SW: be_n = 4'h0; addr[1:0] is ignored.
  - LB / LBU: the byte selected by addr[1:0] is sign- or zero-extended to 32 bits. be_n = 4'h0 during the read.
  - SB: wdata[7:0] is replicated onto all four lanes. be_n is low only on lane addr[1:0].
  - Any other non-NOP code: completes with no strobes and rdata 0.
- FSM states: IDLE → ACCESS → DONE → IDLE.
  - IDLE: latch grant, address, mode and data; load counter = SRAM_WAIT. Go to ACCESS if any request, else stay.
  - ACCESS:
    - ce_n = 0 (hit only).
    - Reads: oe_n = 0 throughout.
    - Writes: we_n = 0 while counter > 0; we_n = 1 on the final ACCESS cycle (data/address hold).
    - Decrement the counter. On counter == 0, register sram_rdata (after lane extraction) and go to DONE.
  - DONE: all strobes high. ready = 1 and rdata driven on the granted port only; the other port's ready = 0. Go to IDLE.
- The non-granted port's rdata holds 0.

## Timing
- Reset values: all strobes 1, be_n 4'hF, sram_addr 0, sram_wdata 0, both ready 0, both rdata 0, state IDLE.
- Latency: request visible in IDLE at cycle 0 → ACCESS cycles 1..SRAM_WAIT+1 → ready at cycle SRAM_WAIT+2.
- Back-to-back requests:
  - The arbiter returns to IDLE at SRAM_WAIT+3, so next grant is earliest SRAM_WAIT+3. The minimum period is SRAM_WAIT+3 cycles.
  - A request still asserted the cycle after ready is treated as a new transaction.
- Simultaneous requests while busy: the waiting port is granted at the next IDLE. Neither port can starve.
- Reset mid-transaction: strobes deassert immediately (asynchronously). No ready is issued and the transaction is dropped.

## Structure
- defs.v (shared) holds:
  - `IO_*` mode codes (existing).
  - New arbiter state codes: `ARB_IDLE`, `ARB_ACCESS`, `ARB_DONE`.
  - New SRAM map constants: `SRAM_BASE_HI` = 10'h200.
- Sub-module io_byte_lane (combinational) does write lane steering plus be_n generation, and read byte extraction/extension. The arbiter and FSM live in io_arbiter.

## Test plan
- Reset, then m0 LW at 0x80000010 with sram_rdata = 0x12345678, SRAM_WAIT = 2:
  - ce_n/oe_n low for 3 cycles, sram_addr = 0x4.
  - m0_ready at cycle 4 with m0_rdata = 0x12345678.
- m0 SB at 0x80000003 with wdata 0x000000A5:
  - be_n = 4'b0111, sram_wdata = 0xA5A5A5A5.
  - we_n low for exactly 2 cycles, then high for 1 hold cycle.
- LB / LBU at 0x80000001 with sram_rdata = 0x0000F000:
  - LB returns rdata = 0xFFFFFFF0.
  - LBU returns rdata = 0x000000F0.
- m0 and m1 both request continuously (LW):
  - Grants alternate m0, m1, m0, m1.
  - Ready pulses are 5 cycles apart, and ready is never high on both ports at once.
- m1 LW at 0x00001000 (unmapped): no strobes ever low; m1_ready at cycle 4 with m1_rdata = 0.
- rst asserted during the 2nd ACCESS cycle of an SW:
  - we_n/ce_n go high in the same cycle.
  - No ready pulse; the next request after reset is serviced normally.

Source files
------------

// File: rtl/io_arbiter_pkg.sv
// rtl/io_arbiter_pkg.sv - IO mode codes, arbiter states and SRAM map constants
package io_arbiter_pkg;

    localparam logic [3:0] IO_NOP = 4'h0;
    localparam logic [3:0] IO_LB  = 4'h1;
    localparam logic [3:0] IO_LBU = 4'h2;
    localparam logic [3:0] IO_LW  = 4'h3;
    localparam logic [3:0] IO_SB  = 4'h4;
    localparam logic [3:0] IO_SW  = 4'h5;

    localparam logic [9:0] SRAM_BASE_HI = 10'h200;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    function automatic logic is_read(input logic [3:0] mode);
        return (mode == IO_LB) || (mode == IO_LBU) || (mode == IO_LW);
    endfunction

    function automatic logic is_write(input logic [3:0] mode);
        return (mode == IO_SB) || (mode == IO_SW);
    endfunction

endpackage

// File: rtl/io_byte_lane.sv
// rtl/io_byte_lane.sv - write lane steering, byte enables and read byte extraction
module io_byte_lane
    import io_arbiter_pkg::*;
(
    input  logic [3:0]  mode_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_n_o,
    output logic [31:0] rdata_o
);

    logic [7:0] rbyte;

    always_comb begin
        rbyte = rdata_i[8*lane_i +: 8];
        wdata_o = wdata_i;
        be_n_o  = 4'hF;
        rdata_o = '0;
        case (mode_i)
            IO_LW: begin
                be_n_o  = 4'h0;
                rdata_o = rdata_i;
            end
            IO_LB: begin
                be_n_o  = 4'h0;
                rdata_o = {{24{rbyte[7]}}, rbyte};
            end
            IO_LBU: begin
                be_n_o  = 4'h0;
                rdata_o = {24'h0, rbyte};
            end
            IO_SW: be_n_o = 4'h0;
            IO_SB: begin
                wdata_o = {4{wdata_i[7:0]}};
                be_n_o  = ~(4'b0001 << lane_i);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - two-port round-robin IO arbiter with fixed wait-state SRAM sequencer
module io_arbiter
    import io_arbiter_pkg::*;
#(
    parameter int SRAM_WAIT = 2,
    parameter int SRAM_AW   = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         m0_mode,
    input  logic [31:0]        m0_addr,
    input  logic [31:0]        m0_wdata,
    output logic [31:0]        m0_rdata,
    output logic               m0_ready,
    input  logic [3:0]         m1_mode,
    input  logic [31:0]        m1_addr,
    input  logic [31:0]        m1_wdata,
    output logic [31:0]        m1_rdata,
    output logic               m1_ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    input  logic [31:0]        sram_rdata,
    output logic [3:0]         sram_be_n,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n
);

    localparam int CW = $clog2(SRAM_WAIT + 1);

    arb_state_e     state_q, state_d;
    logic           grant_q, last_q;
    logic [3:0]     mode_q;
    logic [31:0]    addr_q, wdata_q, rdata_q;
    logic [CW-1:0]  cnt_q;

    logic           req0, req1, gnt;
    logic           hit;
    logic [31:0]    lane_wdata, lane_rdata;
    logic [3:0]     lane_be_n;

    assign req0 = (m0_mode != IO_NOP);
    assign req1 = (m1_mode != IO_NOP);
    // On a tie the port that was not served last wins; last_q resets to 1 so m0 wins first.
    assign gnt  = (req0 && req1) ? ~last_q : req1;
    assign hit  = (addr_q[31:22] == SRAM_BASE_HI);

    io_byte_lane u_lane (
        .mode_i  (mode_q),
        .lane_i  (addr_q[1:0]),
        .wdata_i (wdata_q),
        .rdata_i (sram_rdata),
        .wdata_o (lane_wdata),
        .be_n_o  (lane_be_n),
        .rdata_o (lane_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:   if (req0 || req1) state_d = ARB_ACCESS;
            ARB_ACCESS: if (cnt_q == '0) state_d = ARB_DONE;
            ARB_DONE:   state_d = ARB_IDLE;
            default:    state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            mode_q  <= IO_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else if (state_q == ARB_IDLE) begin
            if (req0 || req1) begin
                grant_q <= gnt;
                last_q  <= gnt;
                mode_q  <= gnt ? m1_mode  : m0_mode;
                addr_q  <= gnt ? m1_addr  : m0_addr;
                wdata_q <= gnt ? m1_wdata : m0_wdata;
                cnt_q   <= CW'(SRAM_WAIT);
            end
        end else if (state_q == ARB_ACCESS) begin
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            else rdata_q <= (hit && is_read(mode_q)) ? lane_rdata : '0;
        end
    end

    assign sram_addr  = addr_q[SRAM_AW+1:2];
    assign sram_wdata = lane_wdata;

    // Strobes decode straight from state so an async reset releases them at once.
    always_comb begin
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_be_n = 4'hF;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        m0_rdata  = '0;
        m1_rdata  = '0;
        if (state_q == ARB_ACCESS && hit && (is_read(mode_q) || is_write(mode_q))) begin
            sram_ce_n = 1'b0;
            sram_be_n = lane_be_n;
            sram_oe_n = ~is_read(mode_q);
            sram_we_n = ~(is_write(mode_q) && cnt_q != '0);
        end
        if (state_q == ARB_DONE) begin
            m0_ready = ~grant_q;
            m1_ready = grant_q;
            m0_rdata = grant_q ? '0 : rdata_q;
            m1_rdata = grant_q ? rdata_q : '0;
        end
    end

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - self-checking bench for io_arbiter
module tb_io_arbiter;
    import io_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  m0_mode, m1_mode;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic [19:0] sram_addr;
    logic [31:0] sram_wdata, sram_rdata;
    logic [3:0]  sram_be_n;
    logic        sram_ce_n, sram_oe_n, sram_we_n;

    io_arbiter #(.SRAM_WAIT(2), .SRAM_AW(20)) dut (
        .clk(clk), .rst(rst),
        .m0_mode(m0_mode), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_mode(m1_mode), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        port;
        logic [3:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] srd;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_be;
        logic [19:0] exp_saddr;
        int          exp_ce;
        int          exp_oe;
        int          exp_we;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } sb_t;

    vec_t vecs[10];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic handle_ready();
        sb_t  e;
        logic p;
        check("ready exclusive", {31'b0, m0_ready & m1_ready}, 32'd0);
        check("scoreboard nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            p = m1_ready;
            check("grant port", {31'b0, p}, {31'b0, e.port});
            check("rdata", p ? m1_rdata : m0_rdata, e.rdata);
            check("other port rdata", p ? m0_rdata : m1_rdata, 32'd0);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        m0_mode = IO_NOP;
        m1_mode = IO_NOP;
        repeat (2) @(negedge clk);
        check("reset strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        check("reset be_n", {28'b0, sram_be_n}, 32'hF);
        check("reset sram_addr", {12'b0, sram_addr}, 32'd0);
        check("reset sram_wdata", sram_wdata, 32'd0);
        check("reset ready", {30'b0, m0_ready, m1_ready}, 32'd0);
        check("reset rdata", m0_rdata | m1_rdata, 32'd0);
        rst = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        int ce_c = 0, oe_c = 0, we_c = 0, rdy_cyc = -1;
        @(negedge clk);
        sram_rdata = v.srd;
        if (!v.port) begin
            m0_mode = v.mode; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_mode = v.mode; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        sb_q.push_back('{v.port, v.exp_rdata});
        for (int c = 1; c <= 8 && rdy_cyc < 0; c++) begin
            @(negedge clk);
            if (!sram_ce_n) ce_c++;
            if (!sram_oe_n) oe_c++;
            if (!sram_we_n) we_c++;
            if (c == 2) begin
                check("be_n", {28'b0, sram_be_n}, {28'b0, (v.exp_ce != 0) ? v.exp_be : 4'hF});
                if (v.exp_ce != 0) begin
                    check("sram_wdata", sram_wdata, v.exp_wdata);
                    check("sram_addr", {12'b0, sram_addr}, {12'b0, v.exp_saddr});
                end
            end
            if (m0_ready || m1_ready) begin
                rdy_cyc = c;
                handle_ready();
                m0_mode = IO_NOP;
                m1_mode = IO_NOP;
            end
        end
        check("ready cycle", rdy_cyc, 32'd4);
        check("ce_n low cycles", ce_c, v.exp_ce);
        check("oe_n low cycles", oe_c, v.exp_oe);
        check("we_n low cycles", we_c, v.exp_we);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   seen, last;
        logic got;
        rst = 1'b1;
        m0_mode = IO_NOP; m0_addr = '0; m0_wdata = '0;
        m1_mode = IO_NOP; m1_addr = '0; m1_wdata = '0;
        sram_rdata = '0;

        //            port  mode    addr          wdata         srd           exp_rdata     exp_wdata     be       saddr     ce oe we
        vecs[0] = '{1'b0, IO_LW,  32'h80000010, 32'h00000000, 32'h12345678, 32'h12345678, 32'h00000000, 4'h0,    20'h00004, 3, 3, 0};
        vecs[1] = '{1'b0, IO_SB,  32'h80000003, 32'h000000A5, 32'h00000000, 32'h00000000, 32'hA5A5A5A5, 4'b0111, 20'h00000, 3, 0, 2};
        vecs[2] = '{1'b0, IO_LB,  32'h80000001, 32'h00000000, 32'h0000F000, 32'hFFFFFFF0, 32'h00000000, 4'h0,    20'h00000, 3, 3, 0};
        vecs[3] = '{1'b0, IO_LBU, 32'h80000001, 32'h00000000, 32'h0000F000, 32'h000000F0, 32'h00000000, 4'h0,    20'h00000, 3, 3, 0};
        vecs[4] = '{1'b1, IO_LW,  32'h00001000, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 4'hF,    20'h00400, 0, 0, 0};
        vecs[5] = '{1'b1, IO_SW,  32'h80000404, 32'hCAFEF00D, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 4'h0,    20'h00101, 3, 0, 2};
        vecs[6] = '{1'b1, IO_LB,  32'h80000002, 32'h00000000, 32'h00800000, 32'hFFFFFF80, 32'h00000000, 4'h0,    20'h00000, 3, 3, 0};
        vecs[7] = '{1'b0, 4'hF,   32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 4'hF,    20'h00000, 0, 0, 0};
        vecs[8] = '{1'b1, IO_LW,  32'h803FFFFC, 32'h00000000, 32'h0BADF00D, 32'h0BADF00D, 32'h00000000, 4'h0,    20'hFFFFF, 3, 3, 0};
        vecs[9] = '{1'b0, IO_LW,  32'h80400000, 32'h00000000, 32'h77777777, 32'h00000000, 32'h00000000, 4'hF,    20'h00000, 0, 0, 0};

        reset_dut();
        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Both ports hammer LW: grants must alternate starting with m0, readies 5 cycles apart.
        reset_dut();
        @(negedge clk);
        sram_rdata = 32'h5A5A0001;
        m0_mode = IO_LW; m0_addr = 32'h80000000; m0_wdata = '0;
        m1_mode = IO_LW; m1_addr = 32'h80000100; m1_wdata = '0;
        for (int k = 0; k < 4; k++) sb_q.push_back('{(k % 2) == 1, 32'h5A5A0001});
        seen = 0;
        last = -1;
        for (int c = 1; c <= 40 && seen < 4; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                handle_ready();
                if (last >= 0) check("ready spacing", c - last, 32'd5);
                else check("first tie ready cycle", c, 32'd4);
                last = c;
                seen++;
            end
        end
        check("arbitrated readies", seen, 32'd4);
        m0_mode = IO_NOP;
        m1_mode = IO_NOP;

        // Reset during the second ACCESS cycle of a store drops it without a ready.
        reset_dut();
        @(negedge clk);
        m0_mode = IO_SW; m0_addr = 32'h80000020; m0_wdata = 32'h00001234;
        @(negedge clk);
        @(negedge clk);
        check("we_n low before reset", {31'b0, sram_we_n}, 32'd0);
        #1 rst = 1'b1;
        #1;
        check("we_n released by reset", {31'b0, sram_we_n}, 32'd1);
        check("ce_n released by reset", {31'b0, sram_ce_n}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        m0_mode = IO_NOP;
        got = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (m0_ready || m1_ready) got = 1'b1;
        end
        check("no ready after reset", {31'b0, got}, 32'd0);
        run_txn(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
